// File: rtl/multi_ch_sync_pkg.sv
// rtl/multi_ch_sync_pkg.sv - parameter limits and counter sizing for multi_ch_sync
package multi_ch_sync_pkg;

   localparam int MIN_CH     = 1;
   localparam int MAX_CH     = 32;
   localparam int MIN_STAGES = 2;
   localparam int MAX_STAGES = 4;
   localparam int MIN_FILT   = 1;
   localparam int MAX_FILT   = 255;

   // Wide enough to hold FILT_CYC itself, although the counter stops at FILT_CYC-1.
   function automatic int cnt_width(input int filt);
      return (filt < 1) ? 1 : $clog2(filt + 1);
   endfunction

endpackage

// File: rtl/msync_chan.sv
// rtl/msync_chan.sv - one-bit synchronizer chain, optional stability filter, edge pulses
// Filter counter present only when MULTI_CH_SYNC_FILTER_EN is defined.
module msync_chan
   import multi_ch_sync_pkg::*;
#(
`ifdef MULTI_CH_SYNC_FILTER_EN
   parameter int   FILT_CYC = 4,
`endif
   parameter int   STAGES   = 2,
   parameter logic RST_VAL  = 1'b0
)(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] chain_q, chain_d;
   logic              q_q, q_d;
   logic              rise_q, rise_d;
   logic              fall_q, fall_d;
   logic              s;

   assign s = chain_q[STAGES-1];

   always_comb begin
      chain_d = {chain_q[STAGES-2:0], i_d};
   end

`ifdef MULTI_CH_SYNC_FILTER_EN
   localparam int             CW       = cnt_width(FILT_CYC);
   localparam logic [CW-1:0]  CNT_LAST = CW'(FILT_CYC - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Any sample that agrees with o_q restarts the count, so only an unbroken run commits.
   always_comb begin
      cnt_d = '0;
      q_d   = q_q;
      if (s != q_q) begin
         if (cnt_q == CNT_LAST) begin
            q_d = s;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   always_comb begin
      q_d = s;
   end
`endif

   always_comb begin
      rise_d = q_d & ~q_q;
      fall_d = ~q_d & q_q;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         chain_q <= {STAGES{RST_VAL}};
         q_q     <= RST_VAL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         chain_q <= chain_d;
         q_q     <= q_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign o_q    = q_q;
   assign o_rise = rise_q;
   assign o_fall = fall_q;

endmodule

// File: rtl/multi_ch_sync.sv
// rtl/multi_ch_sync.sv - NUM_CH independent level synchronizers with edge pulses
// Define MULTI_CH_SYNC_FILTER_EN to add the per-channel FILT_CYC stability filter.
module multi_ch_sync
   import multi_ch_sync_pkg::*;
#(
   parameter int                NUM_CH   = 4,
   parameter int                STAGES   = 2,
   parameter int                FILT_CYC = 4,
   parameter logic [NUM_CH-1:0] RST_VAL  = '0
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [NUM_CH-1:0] i_d,
   output logic [NUM_CH-1:0] o_q,
   output logic [NUM_CH-1:0] o_rise,
   output logic [NUM_CH-1:0] o_fall
);

   if (NUM_CH < MIN_CH || NUM_CH > MAX_CH) begin : g_bad_num_ch
      $error("multi_ch_sync: NUM_CH out of range");
   end
   if (STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_bad_stages
      $error("multi_ch_sync: STAGES out of range");
   end
   if (FILT_CYC < MIN_FILT || FILT_CYC > MAX_FILT) begin : g_bad_filt
      $error("multi_ch_sync: FILT_CYC out of range");
   end

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      msync_chan #(
`ifdef MULTI_CH_SYNC_FILTER_EN
         .FILT_CYC (FILT_CYC),
`endif
         .STAGES   (STAGES),
         .RST_VAL  (RST_VAL[gi])
      ) u_chan (
         .i_clk  (i_clk),
         .i_rst  (i_rst),
         .i_d    (i_d[gi]),
         .o_q    (o_q[gi]),
         .o_rise (o_rise[gi]),
         .o_fall (o_fall[gi])
      );
   end

endmodule

// File: tb/tb_multi_ch_sync.sv
// tb/tb_multi_ch_sync.sv - directed and model-checked bench for multi_ch_sync
module tb_multi_ch_sync;

   localparam int STG = 2;
   localparam int FC  = 4;
`ifdef MULTI_CH_SYNC_FILTER_EN
   localparam int FEFF = FC;
`else
   localparam int FEFF = 1;
`endif
   localparam int LAT = STG + FEFF;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] d0  = 4'h0;
   logic [3:0] d1  = 4'hA;
   logic [3:0] q0, r0, f0, q1, r1, f1;

   int checks   = 0;
   int failures = 0;

   logic [3:0] mc0, mc1, mq, mr, mf;
   int         mcnt [4];

   always #5 clk = ~clk;

   multi_ch_sync #(.NUM_CH(4), .STAGES(STG), .FILT_CYC(FC), .RST_VAL(4'h0)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_d(d0), .o_q(q0), .o_rise(r0), .o_fall(f0));

   multi_ch_sync #(.NUM_CH(4), .STAGES(STG), .FILT_CYC(FC), .RST_VAL(4'hA)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_d(d1), .o_q(q1), .o_rise(r1), .o_fall(f1));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic reset_settle(input logic [3:0] dv);
      rst = 1'b1;
      d0  = dv;
      tick();
      tick();
      rst = 1'b0;
      repeat (LAT + 3) tick();
   endtask

   task automatic test_reset;
      reset_settle(4'h5);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({q0, r0, f0} !== 12'h000) begin
         failures++;
         $display("FAIL reset_dut0 got q=%h r=%h f=%h want q=0 r=0 f=0", q0, r0, f0);
      end
      checks++;
      if ({q1, r1, f1} !== 12'hA00) begin
         failures++;
         $display("FAIL reset_dut1 got q=%h r=%h f=%h want q=a r=0 f=0", q1, r1, f1);
      end
   endtask

   task automatic test_release_all;
      logic [3:0] eq, er;
      rst = 1'b1;
      d0  = 4'hF;
      tick();
      rst = 1'b0;
      for (int k = 1; k <= LAT + 2; k++) begin
         tick();
         eq = (k >= LAT) ? 4'hF : 4'h0;
         er = (k == LAT) ? 4'hF : 4'h0;
         checks++;
         if ({q0, r0, f0} !== {eq, er, 4'h0}) begin
            failures++;
            $display("FAIL release_all k=%0d got q=%h r=%h f=%h want q=%h r=%h f=0", k, q0, r0, f0, eq, er);
         end
      end
   endtask

   task automatic test_single_edge;
      logic [3:0] eq, er;
      reset_settle(4'h0);
      d0 = 4'b0010;
      for (int k = 1; k <= LAT + 1; k++) begin
         tick();
         eq = (k >= LAT) ? 4'b0010 : 4'h0;
         er = (k == LAT) ? 4'b0010 : 4'h0;
         checks++;
         if ({q0, r0, f0} !== {eq, er, 4'h0}) begin
            failures++;
            $display("FAIL single_edge k=%0d got q=%h r=%h f=%h want q=%h r=%h f=0", k, q0, r0, f0, eq, er);
         end
      end
   endtask

   task automatic test_glitch(input int w);
      logic       pass;
      logic [3:0] eq, er, ef;
      pass = (w >= FEFF);
      reset_settle(4'h0);
      d0 = 4'b0001;
      for (int k = 1; k <= LAT + w + 2; k++) begin
         tick();
         eq = (pass && k >= LAT && k < LAT + w) ? 4'b0001 : 4'h0;
         er = (pass && k == LAT) ? 4'b0001 : 4'h0;
         ef = (pass && k == LAT + w) ? 4'b0001 : 4'h0;
         checks++;
         if ({q0, r0, f0} !== {eq, er, ef}) begin
            failures++;
            $display("FAIL glitch_w%0d k=%0d got q=%h r=%h f=%h want q=%h r=%h f=%h", w, k, q0, r0, f0, eq, er, ef);
         end
         if (k == w) d0 = 4'h0;
      end
   endtask

   task automatic test_simultaneous;
      logic [3:0] eq, er, ef;
      reset_settle(4'b1000);
      d0 = 4'b0100;
      for (int k = 1; k <= LAT + 1; k++) begin
         tick();
         eq = (k >= LAT) ? 4'b0100 : 4'b1000;
         er = (k == LAT) ? 4'b0100 : 4'h0;
         ef = (k == LAT) ? 4'b1000 : 4'h0;
         checks++;
         if ({q0, r0, f0} !== {eq, er, ef}) begin
            failures++;
            $display("FAIL simultaneous k=%0d got q=%h r=%h f=%h want q=%h r=%h f=%h", k, q0, r0, f0, eq, er, ef);
         end
      end
   endtask

   task automatic test_reset_mid_filter;
      logic [3:0] eq;
      reset_settle(4'h0);
      d0 = 4'b0001;
      repeat (4) tick();
      eq = (4 >= LAT) ? 4'b0001 : 4'h0;
      checks++;
      if (q0 !== eq) begin
         failures++;
         $display("FAIL mid_filter_pre got q=%h want q=%h", q0, eq);
      end
      #2;
      rst = 1'b1;
      d0  = 4'h0;
      #1;
      checks++;
      if ({q0, r0, f0} !== 12'h000) begin
         failures++;
         $display("FAIL mid_filter_async got q=%h r=%h f=%h want all 0", q0, r0, f0);
      end
      tick();
      tick();
      rst = 1'b0;
      for (int k = 1; k <= LAT + 2; k++) begin
         tick();
         checks++;
         if ({q0, r0, f0} !== 12'h000) begin
            failures++;
            $display("FAIL mid_filter_post k=%0d got q=%h r=%h f=%h want all 0", k, q0, r0, f0);
         end
      end
   endtask

   task automatic model_step(input logic [3:0] din);
      logic [3:0] s, nq;
      s   = mc1;
      mc1 = mc0;
      mc0 = din;
      nq  = mq;
      for (int n = 0; n < 4; n++) begin
         if (s[n] == mq[n]) begin
            mcnt[n] = 0;
         end else if (mcnt[n] == FEFF - 1) begin
            nq[n]   = s[n];
            mcnt[n] = 0;
         end else begin
            mcnt[n] = mcnt[n] + 1;
         end
      end
      mr = nq & ~mq;
      mf = ~nq & mq;
      mq = nq;
   endtask

   task automatic test_random;
      logic [3:0] flip;
      rst = 1'b1;
      d1  = 4'hA;
      tick();
      tick();
      mc0 = 4'hA;
      mc1 = 4'hA;
      mq  = 4'hA;
      mr  = 4'h0;
      mf  = 4'h0;
      for (int n = 0; n < 4; n++) mcnt[n] = 0;
      rst = 1'b0;
      for (int c = 0; c < 500; c++) begin
         for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 3) == 0);
         d1 = d1 ^ flip;
         @(posedge clk);
         model_step(d1);
         #1;
         checks++;
         if ({q1, r1, f1} !== {mq, mr, mf}) begin
            failures++;
            $display("FAIL random c=%0d got q=%h r=%h f=%h want q=%h r=%h f=%h", c, q1, r1, f1, mq, mr, mf);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_release_all();
      test_single_edge();
      test_glitch(3);
      test_glitch(4);
      test_simultaneous();
      test_reset_mid_filter();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
